// File: rtl/vec_inst_queue_if.sv
// rtl/vec_inst_queue_if.sv - issue-side and decode-side handshake bundle for vec_inst_queue
interface vec_inst_queue_if #(
  parameter int INST_W = 32,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [INST_W-1:0] in_inst;
  logic [DATA_W-1:0] in_rs1_data;
  logic [DATA_W-1:0] in_rs2_data;
  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] out_inst;
  logic [DATA_W-1:0] out_rs1_data;
  logic [DATA_W-1:0] out_rs2_data;

  modport master (
    output in_valid, in_inst, in_rs1_data, in_rs2_data, out_ready,
    input  in_ready, out_valid, out_inst, out_rs1_data, out_rs2_data
  );

  modport slave (
    input  in_valid, in_inst, in_rs1_data, in_rs2_data, out_ready,
    output in_ready, out_valid, out_inst, out_rs1_data, out_rs2_data
  );
endinterface

// File: rtl/vec_inst_queue.sv
// rtl/vec_inst_queue.sv - vector instruction queue with config serialisation
// Optional same-cycle empty-queue bypass enabled by defining VIQ_BYPASS_EN.
module vec_inst_queue #(
  parameter int DEPTH  = 4,
  parameter int INST_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  vec_inst_queue_if.slave        bus,
  input  logic                   cfg_done,
  output logic                   drop_pulse,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {STREAM, WAIT_CFG} state_t;

  state_t            state;
  logic [INST_W-1:0] mem_inst [DEPTH];
  logic [DATA_W-1:0] mem_rs1  [DEPTH];
  logic [DATA_W-1:0] mem_rs2  [DEPTH];
  logic [AW-1:0]     head;
  logic [AW-1:0]     tail;

  logic in_is_vec;
  logic accept;
  logic bypass;
  logic push;
  logic pop;
  logic pop_mem;
  logic head_is_cfg;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign in_is_vec = bus.in_inst[6:0] inside {7'h57, 7'h07, 7'h27};
  assign bus.in_ready = !full && !flush;
  assign accept    = bus.in_valid && bus.in_ready;

`ifdef VIQ_BYPASS_EN
  assign bypass = empty && (state == STREAM) && bus.in_valid && in_is_vec && !flush;
  assign bus.out_inst     = bypass ? bus.in_inst     : mem_inst[head];
  assign bus.out_rs1_data = bypass ? bus.in_rs1_data : mem_rs1[head];
  assign bus.out_rs2_data = bypass ? bus.in_rs2_data : mem_rs2[head];
`else
  assign bypass = 1'b0;
  assign bus.out_inst     = mem_inst[head];
  assign bus.out_rs1_data = mem_rs1[head];
  assign bus.out_rs2_data = mem_rs2[head];
`endif

  // WAIT_CFG releases the head in the same cycle cfg_done arrives
  assign bus.out_valid = !flush && (bypass || (!empty && ((state == STREAM) || cfg_done)));
  assign pop         = bus.out_valid && bus.out_ready;
  assign pop_mem     = pop && !empty;
  assign push        = accept && in_is_vec && !(bypass && bus.out_ready);
  assign head_is_cfg = (bus.out_inst[6:0] == 7'h57) && (bus.out_inst[14:12] == 3'b111);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= STREAM;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      drop_pulse <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst[i] <= '0;
        mem_rs1[i]  <= '0;
        mem_rs2[i]  <= '0;
      end
    end else if (flush) begin
      state      <= STREAM;
      tail       <= head;
      count      <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= accept && !in_is_vec;
      if (push) begin
        mem_inst[tail] <= bus.in_inst;
        mem_rs1[tail]  <= bus.in_rs1_data;
        mem_rs2[tail]  <= bus.in_rs2_data;
        tail           <= tail + 1'b1;
      end
      if (pop_mem) begin
        head <= head + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop_mem);
      case (state)
        STREAM: begin
          if (pop && head_is_cfg) state <= WAIT_CFG;
        end
        WAIT_CFG: begin
          // a config popped on the release cycle re-arms the wait
          if (cfg_done && !(pop && head_is_cfg)) state <= STREAM;
        end
        default: state <= STREAM;
      endcase
    end
  end
endmodule

// File: tb/tb_vec_inst_queue.sv
// tb/tb_vec_inst_queue.sv - scoreboard bench for vec_inst_queue
module tb_vec_inst_queue;
  localparam int DEPTH  = 4;
  localparam int INST_W = 32;
  localparam int DATA_W = 32;

  localparam logic [31:0] VADD    = 32'h022180D7;
  localparam logic [31:0] VSETVLI = 32'h0007F557;
  localparam logic [31:0] SCALAR  = 32'h022180B3;

`ifdef VIQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   flush;
  logic                   cfg_done;
  logic                   drop_pulse;
  logic [$clog2(DEPTH):0] count;
  logic                   full;
  logic                   empty;

  vec_inst_queue_if #(.INST_W(INST_W), .DATA_W(DATA_W)) bus ();

  vec_inst_queue #(.DEPTH(DEPTH), .INST_W(INST_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .bus        (bus),
    .cfg_done   (cfg_done),
    .drop_pulse (drop_pulse),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } entry_t;

  entry_t sbq[$];
  entry_t exp_e;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic nedge();
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] inst, input logic [31:0] rs1,
                       input logic [31:0] rs2, input bit stored);
    bus.in_valid    = 1'b1;
    bus.in_inst     = inst;
    bus.in_rs1_data = rs1;
    bus.in_rs2_data = rs2;
    if (stored) sbq.push_back('{inst: inst, rs1: rs1, rs2: rs2});
  endtask

  task automatic idle();
    bus.in_valid    = 1'b0;
    bus.in_inst     = '0;
    bus.in_rs1_data = '0;
    bus.in_rs2_data = '0;
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sbq.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pop: got inst %h expected no output", bus.out_inst);
      end else begin
        exp_e = sbq.pop_front();
        chk("pop_inst", bus.out_inst, exp_e.inst);
        chk("pop_rs1", bus.out_rs1_data, exp_e.rs1);
        chk("pop_rs2", bus.out_rs2_data, exp_e.rs2);
      end
    end
  end

  logic [31:0] vecs [4];

  initial begin
    vecs[0] = 32'h02310157;
    vecs[1] = 32'h02008407;
    vecs[2] = 32'h02008427;
    vecs[3] = 32'h0E4480D7;

    reset_n = 1'b0;
    flush = 1'b0;
    cfg_done = 1'b0;
    bus.out_ready = 1'b0;
    idle();
    repeat (2) cyc();
    nedge();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_drop", 32'(drop_pulse), 32'd0);
    chk("rst_out_inst", bus.out_inst, 32'd0);
    chk("rst_out_rs1", bus.out_rs1_data, 32'd0);
    chk("rst_out_rs2", bus.out_rs2_data, 32'd0);
    cyc();
    reset_n = 1'b1;
    cyc();

    // single push, held by decode
    issue(VADD, 32'h12345678, 32'h87654321, 1'b1);
    cyc();
    idle();
    nedge();
    chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_out_inst", bus.out_inst, VADD);
    chk("t1_rs1", bus.out_rs1_data, 32'h12345678);
    chk("t1_rs2", bus.out_rs2_data, 32'h87654321);
    chk("t1_count", 32'(count), 32'd1);
    cyc();
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;

    // fill, reject fifth, drain in order across the wrap
    for (int i = 0; i < 4; i++) begin
      issue(vecs[i], 32'h100 + 32'(i), 32'h200 + 32'(i), 1'b1);
      nedge();
      chk("t2_in_ready", 32'(bus.in_ready), 32'd1);
      cyc();
    end
    issue(32'h12345057, 32'hDEAD, 32'hBEEF, 1'b0);
    nedge();
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_in_ready_full", 32'(bus.in_ready), 32'd0);
    chk("t2_count_full", 32'(count), 32'd4);
    cyc();
    idle();
    nedge();
    chk("t2_count_after_5th", 32'(count), 32'd4);
    cyc();
    bus.out_ready = 1'b1;
    repeat (4) cyc();
    bus.out_ready = 1'b0;
    nedge();
    chk("t2_empty", 32'(empty), 32'd1);
    chk("t2_count_drained", 32'(count), 32'd0);
    cyc();

    // config serialisation
    bus.out_ready = 1'b1;
    issue(VSETVLI, 32'd64, 32'd0, 1'b1);
    cyc();
    issue(VADD, 32'h11, 32'h22, 1'b1);
    nedge();
    chk("t3_cfg_visible", 32'(bus.out_valid), BYP ? 32'd0 : 32'd1);
    cyc();
    idle();
    for (int i = 0; i < 3; i++) begin
      nedge();
      chk("t3_wait_cfg_stall", 32'(bus.out_valid), 32'd0);
      cyc();
    end
    cfg_done = 1'b1;
    nedge();
    chk("t3_release_valid", 32'(bus.out_valid), 32'd1);
    chk("t3_release_inst", bus.out_inst, VADD);
    cyc();
    cfg_done = 1'b0;
    nedge();
    chk("t3_count", 32'(count), 32'd0);
    cyc();

    // scalar opcode is dropped
    issue(SCALAR, 32'h5, 32'h6, 1'b0);
    nedge();
    chk("t4_in_ready", 32'(bus.in_ready), 32'd1);
    cyc();
    idle();
    nedge();
    chk("t4_drop_pulse", 32'(drop_pulse), 32'd1);
    chk("t4_count", 32'(count), 32'd0);
    chk("t4_out_valid", 32'(bus.out_valid), 32'd0);
    cyc();
    nedge();
    chk("t4_drop_one_cycle", 32'(drop_pulse), 32'd0);
    cyc();

    // flush while waiting on config with queued entries
    issue(VSETVLI, 32'd32, 32'd0, 1'b1);
    cyc();
    for (int i = 0; i < 3; i++) begin
      issue(vecs[i], 32'h300 + 32'(i), 32'h400 + 32'(i), 1'b0);
      cyc();
    end
    idle();
    nedge();
    chk("t5_count_queued", 32'(count), 32'd3);
    chk("t5_wait_valid", 32'(bus.out_valid), 32'd0);
    cyc();
    flush = 1'b1;
    issue(vecs[3], 32'h777, 32'h888, 1'b0);
    nedge();
    chk("t5_flush_in_ready", 32'(bus.in_ready), 32'd0);
    chk("t5_flush_out_valid", 32'(bus.out_valid), 32'd0);
    cyc();
    flush = 1'b0;
    idle();
    cfg_done = 1'b1;
    nedge();
    chk("t5_count_flushed", 32'(count), 32'd0);
    chk("t5_empty_flushed", 32'(empty), 32'd1);
    chk("t5_stray_cfg_valid", 32'(bus.out_valid), 32'd0);
    cyc();
    cfg_done = 1'b0;

    // empty-queue latency (same cycle only with bypass)
    issue(VADD, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1);
    nedge();
    chk("t6_same_cycle_valid", 32'(bus.out_valid), BYP ? 32'd1 : 32'd0);
    if (BYP) chk("t6_same_cycle_inst", bus.out_inst, VADD);
    cyc();
    idle();
    nedge();
    chk("t6_next_cycle_valid", 32'(bus.out_valid), BYP ? 32'd0 : 32'd1);
    chk("t6_count", 32'(count), BYP ? 32'd0 : 32'd1);
    cyc();
    bus.out_ready = 1'b0;

    // asynchronous reset mid-operation
    issue(vecs[0], 32'h1, 32'h2, 1'b0);
    cyc();
    issue(vecs[1], 32'h3, 32'h4, 1'b0);
    cyc();
    idle();
    nedge();
    chk("t7_count_before_rst", 32'(count), 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t7_rst_count", 32'(count), 32'd0);
    chk("t7_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t7_rst_out_inst", bus.out_inst, 32'd0);
    cyc();
    reset_n = 1'b1;
    cyc();

    nedge();
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/vec_inst_queue.md
Name: vec_inst_queue

Overview:
- Decoupling queue between the scalar core's vector-issue port and vec_decode.
- Buffers vector instructions together with the rs1/rs2 scalar operands sampled at issue, and presents them in order to the combinational decoder over a valid/ready handshake.
- Discards non-vector opcodes.
- Serialises configuration instructions: after a vsetvl-class instruction is handed to decode, it stalls until the config unit acknowledges the vl/vtype update.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- INST_W, 32, instruction width.
- DATA_W, 32, scalar operand width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous; discards all entries and any pending config wait.
- in_valid  input  1  issue request from the scalar core.
- in_ready  output  1  queue can accept this cycle.
- in_inst  input  INST_W  instruction word.
- in_rs1_data  input  DATA_W  rs1 value.
- in_rs2_data  input  DATA_W  rs2 value.
- out_valid  output  1  head entry is presented to decode.
- out_ready  input  1  decode consumes the head.
- out_inst  output  INST_W  head instruction, driven to vec_decode.vec_inst.
- out_rs1_data  output  DATA_W  head rs1, driven to vec_decode.rs1_data.
- out_rs2_data  output  DATA_W  head rs2, driven to vec_decode.rs2_data.
- cfg_done  input  1  one-cycle pulse from the config unit: vl/vtype are written.
- drop_pulse  output  1  registered one-cycle pulse when a non-vector instruction is discarded.
- count  output  $clog2(DEPTH)+1  current occupancy.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Reset (reset_n low, asynchronous): count=0, pointers=0, state=STREAM, out_valid=0, drop_pulse=0, empty=1, full=0, in_ready=1. out_inst and both out data ports read 0.
- Vector opcode test on in_inst[6:0]: 0x57 (OP-V), 0x07 (LOAD-FP), 0x27 (STORE-FP).
- Accept: in_valid && in_ready.
  - Vector opcode: instruction and both operands written at the tail; the tail pointer wraps modulo DEPTH.
  - Non-vector opcode: handshake completes, nothing is stored, and drop_pulse=1 in the next cycle.
- in_ready = !full && !flush. It does not depend on out_ready; a full queue does not accept in the same cycle it pops.
- Pop: out_valid && out_ready. The head pointer advances and wraps.
- Simultaneous push and pop with 0<count<DEPTH: count is unchanged.
- Latency, no bypass: a pushed entry appears on out_valid in the next cycle. out_* are read combinationally from the head storage; no output register.
- Configuration instructions are identified by opcode 0x57 && inst[14:12]==3'b111.
- State machine:
  - STREAM: out_valid = !empty. On a pop of a configuration instruction, go to WAIT_CFG.
  - WAIT_CFG: out_valid=0 and the head is held. Pushes are still accepted. When cfg_done=1, return to STREAM and out_valid may assert in that same cycle.
  - cfg_done while in STREAM is ignored.
- Flush: count=0, head=tail, state=STREAM, out_valid=0 in the flush cycle. Any in_valid during flush is not accepted. Flush has priority over cfg_done and over pop.
- Reset asserted mid-operation: immediate return to the reset values; in-flight entries are lost.

Optional Feature:
VIQ_BYPASS_EN
- Defined: when the queue is empty and state=STREAM, a valid vector in_* is forwarded combinationally to out_* with out_valid=1 in the same cycle.
  - If out_ready=1, the entry is not written and count stays 0.
  - If out_ready=0, the entry is written as normal.
  - A bypassed configuration instruction still triggers WAIT_CFG.
  - Non-vector opcodes are never bypassed.
- Undefined: no combinational in-to-out path; minimum latency is one cycle.

Test Plan:
1. Reset, then push 0x022180D7 (vadd.vv v1,v2,v3) with rs1=0x12345678, rs2=0x87654321, out_ready=0 -> next cycle out_valid=1, out_inst=0x022180D7, both operands match, count=1.
2. Push DEPTH=4 distinct vector instructions with out_ready=0 -> full=1, in_ready=0; a fifth in_valid is not accepted. Then pop four with out_ready=1 -> instructions appear in FIFO order, wrap is correct, empty=1.
3. Push 0x0007F557 (vsetvli, rs1=64) then 0x022180D7, out_ready=1 -> vsetvli popped; out_valid=0 for 3 cycles. cfg_done pulsed in cycle 4 -> vadd appears with out_valid=1 in that cycle.
4. Push scalar 0x022180B3 -> accepted (in_ready=1), count stays 0, drop_pulse=1 for exactly one cycle, out_valid never asserts.
5. Three entries queued while in WAIT_CFG, then flush with in_valid=1 in the same cycle -> count=0, state=STREAM, in_ready=0 that cycle, the input is not stored, a later cfg_done is ignored.
6. VIQ_BYPASS_EN defined, queue empty, out_ready=1, push 0x022180D7 -> out_valid=1 and out_inst=0x022180D7 in the same cycle, count remains 0. Without the macro: out_valid in the next cycle.
